// File: rtl/display_scan_controller.sv
// Digit scan and minutes/seconds edit controller for a 4-digit multiplexed
// 7-segment stopwatch display (MM:SS), with an edit-mode inactivity timeout.
module display_scan_controller #(
  parameter int REFRESH_DIV = 25000,
  parameter int TIMEOUT_S   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        clk_1hz,
  input  logic        mode_btn,
  input  logic        inc_btn,
  output logic [3:0]  anode_sel,
  output logic        blink,
  output logic [3:0]  digit_bcd,
  output logic        dp_n,
  output logic        edit_active,
  output logic        inc_min,
  output logic        inc_sec
);

  localparam int              PRE_W       = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [7:0]       TIMEOUT_LIM = 8'(TIMEOUT_S);

  typedef enum logic [1:0] {RUN, EDIT_MIN, EDIT_SEC} state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_prescaler;
  logic [1:0]       r_idx;
  logic [1:0]       r_idx_d;
  logic [7:0]       r_timeout;
  logic             r_clk_1hz_last;

  logic       w_rise;
  logic       w_timed_out;
  logic [7:0] w_timeout_inc;
  logic [3:0] w_digit;

  assign w_rise        = clk_1hz & ~r_clk_1hz_last;
  assign w_timed_out   = (r_timeout == TIMEOUT_LIM);
  assign w_timeout_inc = r_timeout + {7'd0, w_rise};

  // NOTE: every branch writes w_digit, so no latch is inferred.
  always_comb begin
    case (r_idx_d)
      2'd0:    w_digit = digits[3:0];
      2'd1:    w_digit = digits[7:4];
      2'd2:    w_digit = digits[11:8];
      default: w_digit = digits[15:12];
    endcase
  end

  // Scan path: digit_bcd/dp_n use the one-cycle-old index so they line up
  // with the downstream blanking stage's registered anode.
  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescaler    <= '0;
      r_idx          <= 2'd0;
      r_idx_d        <= 2'd0;
      r_clk_1hz_last <= 1'b0;
      anode_sel      <= 4'b1111;
      digit_bcd      <= 4'd0;
      dp_n           <= 1'b1;
    end else begin
      r_clk_1hz_last <= clk_1hz;
      r_idx_d        <= r_idx;
      anode_sel      <= ~(4'b0001 << r_idx);
      digit_bcd      <= w_digit;
      dp_n           <= (r_idx_d != 2'd2);
      if (r_prescaler == PRE_LAST) begin
        r_prescaler <= '0;
        r_idx       <= r_idx + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end
    end
  end

  // Edit FSM; blink and edit_active are computed from the next state so they
  // follow a mode_btn press with a single cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_timeout   <= 8'd0;
      edit_active <= 1'b0;
      blink       <= 1'b0;
      inc_min     <= 1'b0;
      inc_sec     <= 1'b0;
    end else begin
      inc_min <= 1'b0;
      inc_sec <= 1'b0;
      case (r_state)
        EDIT_MIN: begin
          if (mode_btn) begin
            r_state   <= EDIT_SEC;
            r_timeout <= 8'd0;
            blink     <= ~r_idx[1];
          end else if (inc_btn) begin
            inc_min   <= 1'b1;
            r_timeout <= 8'd0;
            blink     <= r_idx[1];
          end else if (w_timed_out) begin
            r_state     <= RUN;
            r_timeout   <= 8'd0;
            edit_active <= 1'b0;
            blink       <= 1'b0;
          end else begin
            r_timeout <= w_timeout_inc;
            blink     <= r_idx[1];
          end
        end
        EDIT_SEC: begin
          if (mode_btn) begin
            r_state     <= RUN;
            r_timeout   <= 8'd0;
            edit_active <= 1'b0;
            blink       <= 1'b0;
          end else if (inc_btn) begin
            inc_sec   <= 1'b1;
            r_timeout <= 8'd0;
            blink     <= ~r_idx[1];
          end else if (w_timed_out) begin
            r_state     <= RUN;
            r_timeout   <= 8'd0;
            edit_active <= 1'b0;
            blink       <= 1'b0;
          end else begin
            r_timeout <= w_timeout_inc;
            blink     <= ~r_idx[1];
          end
        end
        default: begin
          r_timeout <= 8'd0;
          if (mode_btn) begin
            r_state     <= EDIT_MIN;
            edit_active <= 1'b1;
            blink       <= r_idx[1];
          end else begin
            r_state     <= RUN;
            edit_active <= 1'b0;
            blink       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Scan and edit-mode controller for the stopwatch's 4-digit multiplexed 7-segment display. It time-multiplexes the four BCD digits (MM:SS) onto one shared segment bus. It generates the active-low anode select and per-digit blink request consumed by the downstream anode blanking stage. It also runs the minutes/seconds edit state machine that turns button pulses into increment strobes for the time counter.

## Interface
Parameters:
- REFRESH_DIV, 25000, clk cycles each digit stays selected (must be ≥ 2)
- TIMEOUT_S, 10, clk_1hz rising edges without a button pulse before edit mode exits (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- digits  in  16  BCD time: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones
- clk_1hz  in  1  1 Hz square wave, synchronous to clk
- mode_btn  in  1  debounced single-cycle pulse, advances edit state
- inc_btn  in  1  debounced single-cycle pulse, increments the field being edited
- anode_sel  out  4  one-hot active-low digit select, to the blanking stage's anode input
- blink  out  1  blink request for the currently selected digit
- digit_bcd  out  4  BCD value for the segment decoder
- dp_n  out  1  active-low decimal point, lit on digit 2 (colon position)
- edit_active  out  1  high in any edit state; stopwatch counting is paused while high
- inc_min  out  1  one-cycle strobe: increment minutes
- inc_sec  out  1  one-cycle strobe: increment seconds

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the terminal count, digit index idx (2 bits) advances 0→1→2→3→0.
- anode_sel is registered every cycle as ~(1 << idx). Digit 0 is sec ones and digit 3 is min tens.
- digit_bcd and dp_n are registered from the previous cycle's idx. They therefore lag anode_sel by one cycle, matching the one-cycle register in the downstream blanking stage.
- dp_n = 0 when the lagged idx = 2, else 1.
- FSM states: RUN, EDIT_MIN, EDIT_SEC.
  - mode_btn: RUN→EDIT_MIN→EDIT_SEC→RUN.
  - inc_btn in EDIT_MIN pulses inc_min. In EDIT_SEC it pulses inc_sec. In RUN it is ignored.
  - If mode_btn and inc_btn are high in the same cycle, mode_btn wins and no strobe is issued.
- blink = 1 when (EDIT_MIN and idx ∈ {2,3}) or (EDIT_SEC and idx ∈ {0,1}). It is registered alongside anode_sel. In RUN, blink = 0.
- Edit timeout:
  - clk_1hz is edge-detected through a registered last value.
  - The 8-bit timeout counter clears on entering an edit state and on any mode_btn or inc_btn pulse.
  - The counter increments on each clk_1hz rising edge while in an edit state.
  - When the counter reaches TIMEOUT_S, the FSM returns to RUN on the next cycle.
  - A button pulse in the same cycle as the final edge takes priority: the counter clears and the FSM stays in its state.
- edit_active = (state != RUN), registered with the state.

## Timing
- Reset values (while rst_n = 0 at a clk edge):
  - Outputs: anode_sel = 4'b1111, blink = 0, digit_bcd = 0, dp_n = 1, edit_active = 0, inc_min = inc_sec = 0.
  - Internal: state = RUN, idx = 0, prescaler = 0, timeout = 0, clk_1hz_last = 0.
- First cycle after reset release: anode_sel = 4'b1110. The following cycle: digit_bcd = digits[3:0].
- Each digit is selected for exactly REFRESH_DIV cycles. A full scan takes 4·REFRESH_DIV cycles.
- Strobe latency: inc_min or inc_sec is high in the cycle after the inc_btn pulse, for exactly one cycle.
- State change takes one cycle: edit_active and blink reflect the new state in the cycle after mode_btn.
- digits is sampled with no buffering. A change appears on digit_bcd at the next selection of that digit position.
- If clk_1hz is high at reset release, the first cycle sees a rising edge. The edge is counted only in edit states.
- Reset mid-edit: returns to RUN immediately, with no strobe.

## Test plan
- Reset and scan, REFRESH_DIV=4, digits=16'h1234:
  - anode_sel steps 1110, 1101, 1011, 0111, each for 4 cycles, and wraps.
  - digit_bcd lags by 1 cycle: 4, 3, 2, 1.
  - dp_n = 0 only while digit_bcd = 2.
- Mode cycling:
  - First mode_btn: edit_active = 1, and blink = 1 only when anode_sel ∈ {1011, 0111}.
  - Second mode_btn: blink = 1 only when anode_sel ∈ {1110, 1101}.
  - Third mode_btn: RUN, with edit_active = 0 and blink = 0.
- Increment strobes:
  - inc_btn in EDIT_MIN gives one inc_min cycle.
  - inc_btn in EDIT_SEC gives one inc_sec cycle.
  - inc_btn in RUN gives no strobe.
  - mode_btn and inc_btn together in EDIT_MIN move to EDIT_SEC with no strobe.
- Timeout, TIMEOUT_S=3:
  - Enter EDIT_MIN and apply 3 clk_1hz rising edges: RUN one cycle after the 3rd edge.
  - Repeat with an inc_btn pulse after the 2nd edge: still in edit after 3 more edges total, exits on the 3rd edge after the pulse.
- Reset mid-edit: assert rst_n = 0 for 1 cycle in EDIT_SEC → all outputs at their reset values, then the scan restarts at 1110.
